// File: rtl/div_iter_unit_pkg.sv
// div_iter_unit_pkg: FSM state encodings and handshake constants for the iterative divider.
package div_iter_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic [31:0] ZeroWord   = 32'h0;

endpackage

// File: rtl/div_iter_unit_step.sv
// div_step: one combinational radix-2 restoring step over WIDTH+1 bits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q
);

    logic [WIDTH:0] diff;

    // partial < 2*divisor, so a non-negative difference always fits WIDTH bits
    assign diff     = partial - {1'b0, divisor};
    assign q        = ~diff[WIDTH];
    assign rem_next = q ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/div_iter_unit.sv
// div_iter_unit: multi-cycle radix-2 restoring divider returning {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: finish after the first ON cycle when |dividend| < |divisor|.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH);

    div_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic sgn, sgn_n, neg_a, neg_a_n, neg_b, neg_b_n;
    logic [WIDTH-1:0] rem, rem_n, dvd, dvd_n, dvs, dvs_n;
    logic [WIDTH-1:0] rem_step, q_raw, r_raw, q_fix, r_fix, a_mag, b_mag;
    logic q_bit, early, by_zero, abort;
    logic [2*WIDTH-1:0] result_n;
    logic ready_n;

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial  ({rem, dvd[WIDTH-1]}),
        .divisor  (dvs),
        .rem_next (rem_step),
        .q        (q_bit)
    );

`ifdef DIV_EARLY_OUT_EN
    assign early = (cnt == '0) && (dvd < dvs);
`else
    assign early = 1'b0;
`endif

    assign by_zero = opdata2_i == WIDTH'(ZeroWord);
    assign abort   = annul_i || start_i == DivStop;
    assign a_mag   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign b_mag   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign q_raw   = early ? '0 : {dvd[WIDTH-2:0], q_bit};
    assign r_raw   = early ? dvd : rem_step;
    // two's-complement negation also gives the wrap case (min / -1 = min)
    assign q_fix   = (sgn && (neg_a != neg_b)) ? -q_raw : q_raw;
    assign r_fix   = (sgn && neg_a) ? -r_raw : r_raw;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sgn_n    = sgn;
        neg_a_n  = neg_a;
        neg_b_n  = neg_b;
        rem_n    = rem;
        dvd_n    = dvd;
        dvs_n    = dvs;
        result_n = result_o;
        ready_n  = ready_o;
        case (state)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    sgn_n   = signed_div_i;
                    neg_a_n = signed_div_i & opdata1_i[WIDTH-1];
                    neg_b_n = signed_div_i & opdata2_i[WIDTH-1];
                    cnt_n   = '0;
                    rem_n   = '0;
                    dvd_n   = by_zero ? opdata1_i : a_mag;
                    dvs_n   = b_mag;
                    state_n = by_zero ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                state_n = abort ? DivFree : DivEnd;
                if (!abort) begin
                    ready_n  = DivResultReady;
                    result_n = {dvd, {WIDTH{1'b1}}};
                end
            end
            DivOn: begin
                if (abort) begin
                    state_n = DivFree;
                end else if (early || cnt == CW'(WIDTH - 1)) begin
                    state_n  = DivEnd;
                    ready_n  = DivResultReady;
                    result_n = {r_fix, q_fix};
                end else begin
                    rem_n = rem_step;
                    dvd_n = {dvd[WIDTH-2:0], q_bit};
                    cnt_n = cnt + 1'b1;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_n  = DivFree;
                    ready_n  = DivResultNotReady;
                    result_n = '0;
                end
            end
            default: state_n = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            sgn      <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sgn      <= sgn_n;
            neg_a    <= neg_a_n;
            neg_b    <= neg_b_n;
            rem      <= rem_n;
            dvd      <= dvd_n;
            dvs      <= dvs_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed self-checking bench for div_iter_unit (WIDTH=32).
module tb_div_iter_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  int errors = 0;
  int checks = 0;
  int lat;
  int seen;
  logic [63:0] res, res_after;
  logic rdy_after;

  div_iter_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic s, input logic [31:0] a, input logic [31:0] b,
                    output int l, output logic [63:0] r,
                    output logic ra, output logic [63:0] rr);
    @(posedge clk); #1;
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    l = -1;
    r = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      opdata1_i = 32'hDEADBEEF;
      opdata2_i = 32'h00000005;
      if (ready_o) begin
        l = k;
        r = result_o;
        break;
      end
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    ra = ready_o;
    rr = result_o;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready_o, 1'b0);
    chk("reset_result", result_o, 64'h0);
    rst = 1'b0;
    op(1'b0, 32'd100, 32'd7, lat, res, rdy_after, res_after);
    chk("udiv_latency", lat, 33);
    chk("udiv_result", res, {32'd2, 32'd14});
    chk("udiv_ready_drop", rdy_after, 1'b0);
    chk("udiv_result_clear", res_after, 64'h0);
    op(1'b1, 32'hFFFFFFF9, 32'h00000002, lat, res, rdy_after, res_after);
    chk("sdiv_neg_result", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("sdiv_neg_latency", lat, 33);
    op(1'b0, 32'hFFFFFFF9, 32'h00000002, lat, res, rdy_after, res_after);
    chk("udiv_big_result", res, {32'h00000001, 32'h7FFFFFFC});
    op(1'b1, 32'h00000007, 32'hFFFFFFFE, lat, res, rdy_after, res_after);
    chk("sdiv_negdivisor_result", res, {32'h00000001, 32'hFFFFFFFD});
    op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res, rdy_after, res_after);
    chk("sdiv_wrap_result", res, {32'h00000000, 32'h80000000});
    chk("sdiv_wrap_latency", lat, 33);
    chk("sdiv_wrap_ready_drop", rdy_after, 1'b0);
    op(1'b1, 32'h00001234, 32'h0, lat, res, rdy_after, res_after);
    chk("sdiv0_latency", lat, 2);
    chk("sdiv0_result", res, {32'h00001234, 32'hFFFFFFFF});
    op(1'b0, 32'h00001234, 32'h0, lat, res, rdy_after, res_after);
    chk("udiv0_latency", lat, 2);
    chk("udiv0_result", res, {32'h00001234, 32'hFFFFFFFF});
    chk("udiv0_result_clear", res_after, 64'h0);
    @(posedge clk); #1;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o) seen++;
      @(posedge clk); #1;
    end
    chk("annul_no_ready", seen, 0);
    op(1'b0, 32'd9, 32'd3, lat, res, rdy_after, res_after);
    chk("after_annul_latency", lat, 33);
    chk("after_annul_result", res, {32'd0, 32'd3});
    @(posedge clk); #1;
    signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_ready", ready_o, 1'b0);
    chk("midreset_result", result_o, 64'h0);
    start_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk("midreset_no_ready", seen, 0);
    @(posedge clk); #1;
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    chk("hold_ready_first", ready_o, 1'b1);
    opdata1_i = 32'd50; opdata2_i = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_ready_still", ready_o, 1'b1);
    chk("hold_result", result_o, {32'd2, 32'd14});
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("hold_release_ready", ready_o, 1'b0);
    op(1'b0, 32'd3, 32'd10, lat, res, rdy_after, res_after);
    chk("small_result", res, {32'd3, 32'd0});
`ifdef DIV_EARLY_OUT_EN
    chk("small_latency", lat, 2);
`else
    chk("small_latency", lat, 33);
`endif
    op(1'b1, 32'hFFFFFFFD, 32'd10, lat, res, rdy_after, res_after);
    chk("small_signed_result", res, {32'hFFFFFFFD, 32'd0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
Multi-cycle iterative divider. It is the responder side of the EX-stage divide handshake (start_i / ready_o).
- EX presents operands and holds start_i while ready_o is low.
- The unit latches the operands, runs radix-2 restoring division and returns {remainder, quotient}.
- HI is written from the upper half of the result, LO from the lower half.
- Serves DIV and DIVU.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
start_i  input  1  request; held high by EX until ready_o seen
annul_i  input  1  abort in-flight operation
result_o  output  2*WIDTH  {remainder, quotient}; valid only while ready_o=1, else 0
ready_o  output  1  result valid

Behaviour:
- Reset: state FREE, ready_o=0, result_o=0, counter=0, operand registers=0. Reset mid-operation discards all work; the next cycle is FREE.
- All outputs are registered.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0: latch signed_div_i, the operands and the sign bits.
  - Divisor==0 -> BY_ZERO. Otherwise latch |dividend| and |divisor| (magnitudes only when signed) and go to ON with counter=0.
  - Otherwise stay in FREE.
- BY_ZERO: result = {dividend as latched, all-ones quotient}; go to END. Rule applies for both signed and unsigned.
- ON:
  - One restoring step per cycle: shift {partial remainder, dividend} left 1, trial-subtract the divisor, set quotient bit to 1 if no borrow, else restore.
  - Counter increments per step. After WIDTH steps, apply sign fix and go to END.
- Sign fix (signed only):
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Two's-complement wrap: 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- END:
  - ready_o=1, result_o holds the result.
  - start_i=0 -> FREE, with ready_o and result_o cleared on the next edge.
  - start_i=1 -> stay in END holding the result; no restart.
  - EX drops start combinationally on ready, so ready_o is asserted for exactly one cycle.
- Latency: start first high in cycle N (state FREE) -> ready_o high in cycle N+WIDTH+1 (N+33). Divide-by-zero: N+2.
- Abort: annul_i=1 or start_i=0 while in ON or BY_ZERO -> FREE next cycle; ready_o never asserts for that operation.
- Simultaneous events: rst has priority over annul_i, which has priority over start_i.
- Operand changes after latching are ignored.
- Back-to-back operations: a new start in the cycle after END->FREE is accepted normally.

Optional Feature:
DIV_EARLY_OUT_EN:
- Defined: in FREE, if the latched magnitudes satisfy |dividend| < |divisor| (divisor nonzero), skip ON and go directly to END with quotient=0 and remainder=original dividend (sign preserved). Latency is N+2.
- Undefined: every nonzero divisor takes the full WIDTH iterations.
- Results are identical either way; only latency differs.

Decomposition:
- defines.vh holds:
  - state encodings: DivFree, DivByZero, DivOn, DivEnd
  - handshake constants: DivStart, DivStop, DivResultReady, DivResultNotReady
  - ZeroWord
- One natural sub-module, div_step: combinational single restoring step of WIDTH+1 bits, input {partial remainder, divisor}, output {next remainder, quotient bit}.
- Sign fix stays inline.

Test Plan:
- Unsigned 100/7, start held until ready -> ready_o at N+33 for exactly 1 cycle, result_o={32'd2, 32'd14}; 0 the next cycle.
- Signed 0xFFFFFFF9 / 0x00000002 -> result_o={0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quot -3); unsigned same operands -> {0x00000001, 0x7FFFFFFC}.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}, no hang.
- Divide by zero 0x00001234 / 0 (signed and unsigned) -> ready_o at N+2, result_o={0x00001234, 0xFFFFFFFF}.
- annul_i pulsed at N+10 -> ready_o stays 0, FREE at N+11; new start 9/3 -> {0, 3} at start+33.
- rst asserted at N+5 mid-division -> next cycle ready_o=0, result_o=0. With DIV_EARLY_OUT_EN, 3/10 -> {3, 0} at N+2; without it, same result at N+33.
